// File: rtl/pipe_drain_buffer.sv
// -----------------------------------------------------------------------------
// pipe_drain_buffer
//
// Receiving end of the SM4 stallable datapath. Words leaving the last stage of
// the stall-frozen delay pipeline are stored in a small FIFO. When the FIFO is
// full, `stall` freezes every pipeline stage so that the word at the pipeline
// output is held, not lost. The consumer drains the FIFO via valid/ready.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset (control state only)
//   in_valid   in   pipeline output stage holds a valid word
//   in_data    in   word from the pipeline output stage
//   stall      out  freeze command to all pipeline stages (FIFO full)
//   flush      in   synchronous clear of FIFO occupancy
//   out_valid  out  FIFO head holds a word
//   out_data   out  FIFO head word
//   out_ready  in   consumer accepts the head word this cycle
//   level      out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module pipe_drain_buffer #(
    parameter int WORD_WIDTH = 128,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  level
);

    localparam int                   PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  push;
    logic                  pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // All outputs decode from registers only; in_valid/out_ready never reach
    // stall, out_valid or out_data combinationally.
    assign stall     = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign level     = count;

    // A full FIFO refuses the push even if a pop happens in the same cycle;
    // the held word is accepted one cycle later (no full-bypass).
    assign push = in_valid & ~stall;
    assign pop  = out_valid & out_ready;

    // Storage is not reset; contents behind rd_ptr..wr_ptr are don't-care.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
